sd_arbiter: RTL and testbench
=============================

SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 24'd2000000, meaning the REQ-state cycles to wait for sd_ack before aborting.
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 For N=0,1 the block SHALL have port rN_lba, input, 32, the sector address of requester N.
REQ-005 For N=0,1 the block SHALL have port rN_rd, input, 1, the read-sector request.
REQ-006 For N=0,1 the block SHALL have port rN_wr, input, 1, the write-sector request.
REQ-007 For N=0,1 the block SHALL have port rN_ack, output, 1, high while requester N's transfer is in progress.
REQ-008 For N=0,1 the block SHALL have port rN_dout, output, 8, the read data byte.
REQ-009 For N=0,1 the block SHALL have port rN_dout_strobe, output, 1, a one-cycle pulse marking rN_dout valid.
REQ-010 For N=0,1 the block SHALL have port rN_din, input, 8, the write data byte.
REQ-011 For N=0,1 the block SHALL have port rN_din_strobe, output, 1, a one-cycle pulse requesting the next rN_din.
REQ-012 For N=0,1 the block SHALL have port rN_err, output, 1, a one-cycle pulse flagging a timeout or a short read.
REQ-013 The block SHALL have port sd_lba, output, 32, the latched LBA driven to the SPI IO bridge.
REQ-014 The block SHALL have ports sd_rd and sd_wr, each output, 1, the command request to the IO bridge.
REQ-015 The block SHALL have port sd_ack, input, 1, the IO bridge acknowledge in the SPI clock domain.
REQ-016 The block SHALL have ports sd_dout, input, 8, and sd_dout_strobe, input, 1, the IO-to-FPGA byte and its strobe, both in the SPI domain.
REQ-017 The block SHALL have ports sd_din, output, 8, and sd_din_strobe, input, 1, the FPGA-to-IO byte and its SPI-domain fetch strobe.

Function
REQ-018 sd_ack, sd_dout_strobe and sd_din_strobe SHALL each pass through a 2-flop synchronizer; a strobe event is a synchronized rising edge, one clk pulse.
REQ-019 sd_dout SHALL be captured into the rN_dout register on the dout strobe event; clk SHALL be at least 4x the SPI byte rate.
REQ-020 The FSM SHALL have exactly four states: IDLE, REQ, XFER and DONE.
REQ-021 In IDLE with any rN_rd|rN_wr high, the block SHALL grant round-robin, with the last-granted requester losing ties, latch lba and direction, and enter REQ on the next cycle.
REQ-022 If rN_rd and rN_wr are both high, the request SHALL be treated as a read.
REQ-023 In REQ, the block SHALL drive sd_lba with the latched value and sd_rd or sd_wr high, and SHALL enter XFER on the synchronized sd_ack rising edge while dropping sd_rd/sd_wr in the same cycle.
REQ-024 In XFER, rN_ack of the granted requester SHALL be high, and each dout event SHALL produce one rN_dout_strobe pulse, with latency of 1 clk after the event.
REQ-025 In XFER, each din event SHALL produce one rN_din_strobe pulse, and sd_din SHALL combinationally mux rN_din of the granted requester.
REQ-026 A 10-bit byte counter SHALL count dout events per read; events after 512 SHALL be dropped with no strobe.
REQ-027 On synchronized sd_ack falling, the block SHALL enter DONE; rN_err SHALL pulse if the transfer is a read and the count is not 512; writes SHALL not be count-checked.
REQ-028 DONE SHALL last one cycle: rN_ack low, round-robin pointer updated, then IDLE; a request still held high SHALL be re-arbitrated as new.
REQ-029 Non-granted requester outputs SHALL stay 0 at all times.

Reset
REQ-030 While reset_n is low: state IDLE; all outputs, counters and rN_dout 0; synchronizers cleared; round-robin pointer set so r0 wins the first tie.
REQ-031 Reset asserted mid-transfer SHALL abort immediately with no err pulse.

Configuration
REQ-032 With SD_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL clear on REQ entry, and reaching TIMEOUT_CYCLES SHALL drop sd_rd/sd_wr, enter DONE and pulse rN_err.
REQ-033 Without SD_ARB_TIMEOUT_EN, the counter SHALL be absent and REQ SHALL wait indefinitely.

Verification
REQ-034 r0_rd, lba 0x1234, bridge acks and sends 512 bytes 0x00..0xFF twice -> sd_rd high with sd_lba 0x1234, 512 r0_dout_strobe pulses in order, no r0_err.
REQ-035 r0_rd and r1_wr raised in the same cycle after reset -> r0 is served first, then r1 with sd_wr high; a repeat tie goes to r0 again only after r1 is served.
REQ-036 Read where the bridge sends 300 bytes then drops sd_ack -> one r0_err pulse in DONE.
REQ-037 With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, no sd_ack -> sd_rd drops and r1_err pulses at REQ cycle 100; without the macro, sd_rd is still high at cycle 10000.
REQ-038 r1 write of 513 din events -> 513 r1_din_strobe pulses, sd_din tracks r1_din, no err.
REQ-039 reset_n pulsed low at byte 200 of a read -> all outputs 0, state IDLE, next request handled normally.

Source files
------------

// File: rtl/sd_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sd_arbiter_if : requester and SPI IO bridge bundle for sd_arbiter
// Rev 1.0
// ============================================================================
interface sd_arbiter_if;
    logic [31:0] r0_lba,         r1_lba;
    logic        r0_rd,          r1_rd;
    logic        r0_wr,          r1_wr;
    logic        r0_ack,         r1_ack;
    logic [7:0]  r0_dout,        r1_dout;
    logic        r0_dout_strobe, r1_dout_strobe;
    logic [7:0]  r0_din,         r1_din;
    logic        r0_din_strobe,  r1_din_strobe;
    logic        r0_err,         r1_err;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic [7:0]  sd_din;
    logic        sd_din_strobe;

    modport slave (
        input  r0_lba, r0_rd, r0_wr, r0_din,
        input  r1_lba, r1_rd, r1_wr, r1_din,
        output r0_ack, r0_dout, r0_dout_strobe, r0_din_strobe, r0_err,
        output r1_ack, r1_dout, r1_dout_strobe, r1_din_strobe, r1_err,
        output sd_lba, sd_rd, sd_wr, sd_din,
        input  sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
    );

    modport master (
        output r0_lba, r0_rd, r0_wr, r0_din,
        output r1_lba, r1_rd, r1_wr, r1_din,
        input  r0_ack, r0_dout, r0_dout_strobe, r0_din_strobe, r0_err,
        input  r1_ack, r1_dout, r1_dout_strobe, r1_din_strobe, r1_err,
        input  sd_lba, sd_rd, sd_wr, sd_din,
        output sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
    );
endinterface
`default_nettype wire

// File: rtl/sd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sd_arbiter : two-requester round-robin arbiter onto one SPI SD IO bridge.
// Optional REQ-state timeout enabled by defining SD_ARB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module sd_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    sd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [9:0] c_SECTOR_BYTES = 10'd512;
`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [23:0] c_TMO_LAST = TIMEOUT_CYCLES - 24'd1;
`endif

    state_t      state_q;
    logic [2:0]  ack_sync_q, dout_sync_q, din_sync_q;
    logic        gnt_q, last_q, rd_q;
    logic [31:0] lba_q;
    logic        sd_rd_q, sd_wr_q;
    logic [1:0]  ack_q, dout_stb_q, din_stb_q, err_q;
    logic [7:0]  dout0_q, dout1_q;
    logic [9:0]  cnt_q;
`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_q;
`endif

    logic        w_req0, w_req1, w_gnt, w_rd_sel;
    logic [31:0] w_lba_sel;
    logic [1:0]  w_gnt_oh;
    logic        w_ack_rise, w_ack_fall, w_dout_evt, w_din_evt;

    assign w_req0     = bus.r0_rd | bus.r0_wr;
    assign w_req1     = bus.r1_rd | bus.r1_wr;
    // On a tie the requester granted last time loses.
    assign w_gnt      = (w_req0 & w_req1) ? ~last_q : w_req1;
    assign w_rd_sel   = w_gnt ? bus.r1_rd  : bus.r0_rd;
    assign w_lba_sel  = w_gnt ? bus.r1_lba : bus.r0_lba;
    assign w_gnt_oh   = {gnt_q, ~gnt_q};
    assign w_ack_rise =  ack_sync_q[1]  & ~ack_sync_q[2];
    assign w_ack_fall = ~ack_sync_q[1]  &  ack_sync_q[2];
    assign w_dout_evt =  dout_sync_q[1] & ~dout_sync_q[2];
    assign w_din_evt  =  din_sync_q[1]  & ~din_sync_q[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ack_sync_q  <= 3'b000;
            dout_sync_q <= 3'b000;
            din_sync_q  <= 3'b000;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            rd_q        <= 1'b0;
            lba_q       <= 32'h0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            ack_q       <= 2'b00;
            dout_stb_q  <= 2'b00;
            din_stb_q   <= 2'b00;
            err_q       <= 2'b00;
            dout0_q     <= 8'h00;
            dout1_q     <= 8'h00;
            cnt_q       <= 10'd0;
`ifdef SD_ARB_TIMEOUT_EN
            tmo_q       <= 24'd0;
`endif
        end else begin
            ack_sync_q  <= {ack_sync_q[1:0],  bus.sd_ack};
            dout_sync_q <= {dout_sync_q[1:0], bus.sd_dout_strobe};
            din_sync_q  <= {din_sync_q[1:0],  bus.sd_din_strobe};
            dout_stb_q  <= 2'b00;
            din_stb_q   <= 2'b00;
            err_q       <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        gnt_q   <= w_gnt;
                        rd_q    <= w_rd_sel;
                        lba_q   <= w_lba_sel;
                        sd_rd_q <= w_rd_sel;
                        sd_wr_q <= ~w_rd_sel;
                        cnt_q   <= 10'd0;
`ifdef SD_ARB_TIMEOUT_EN
                        tmo_q   <= 24'd0;
`endif
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack_rise) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        ack_q   <= w_gnt_oh;
                        state_q <= S_XFER;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (tmo_q == c_TMO_LAST) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        err_q   <= w_gnt_oh;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q   <= tmo_q + 24'd1;
                    end
`endif
                end
                S_XFER: begin
                    if (w_ack_fall) begin
                        ack_q   <= 2'b00;
                        if (rd_q && (cnt_q != c_SECTOR_BYTES)) begin
                            err_q <= w_gnt_oh;
                        end
                        state_q <= S_DONE;
                    end
                    // Bytes beyond one sector are silently discarded.
                    if (w_dout_evt && (cnt_q != c_SECTOR_BYTES)) begin
                        cnt_q      <= cnt_q + 10'd1;
                        dout_stb_q <= w_gnt_oh;
                        if (gnt_q) begin
                            dout1_q <= bus.sd_dout;
                        end else begin
                            dout0_q <= bus.sd_dout;
                        end
                    end
                    if (w_din_evt) begin
                        din_stb_q <= w_gnt_oh;
                    end
                end
                S_DONE: begin
                    last_q  <= gnt_q;
                    dout0_q <= 8'h00;
                    dout1_q <= 8'h00;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.r0_ack         = ack_q[0];
    assign bus.r1_ack         = ack_q[1];
    assign bus.r0_dout        = dout0_q;
    assign bus.r1_dout        = dout1_q;
    assign bus.r0_dout_strobe = dout_stb_q[0];
    assign bus.r1_dout_strobe = dout_stb_q[1];
    assign bus.r0_din_strobe  = din_stb_q[0];
    assign bus.r1_din_strobe  = din_stb_q[1];
    assign bus.r0_err         = err_q[0];
    assign bus.r1_err         = err_q[1];
    assign bus.sd_lba         = lba_q;
    assign bus.sd_rd          = sd_rd_q;
    assign bus.sd_wr          = sd_wr_q;
    assign bus.sd_din         = (state_q == S_XFER) ? (gnt_q ? bus.r1_din : bus.r0_din) : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_sd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sd_arbiter : self-checking bench for sd_arbiter with a read-byte scoreboard
// Rev 1.0
// ============================================================================
module tb_sd_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sd_arbiter_if bus();
    sd_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] e0, e1;
    int n_dstb0 = 0, n_dstb1 = 0, n_istb0 = 0, n_istb1 = 0;
    int n_errp0 = 0, n_errp1 = 0, n_cross = 0;

    // Scoreboard consumer: every read strobe pops the next expected byte.
    always @(negedge clk) begin
        if (bus.r0_dout_strobe) begin
            n_dstb0++;
            n_vec++;
            if (exp0.size() == 0) begin
                n_err++;
                $display("FAIL dout0_extra: got %h, no byte expected", bus.r0_dout);
            end else begin
                e0 = exp0.pop_front();
                if (bus.r0_dout !== e0) begin
                    n_err++;
                    $display("FAIL dout0: got %h, required %h", bus.r0_dout, e0);
                end
            end
        end
        if (bus.r1_dout_strobe) begin
            n_dstb1++;
            n_vec++;
            if (exp1.size() == 0) begin
                n_err++;
                $display("FAIL dout1_extra: got %h, no byte expected", bus.r1_dout);
            end else begin
                e1 = exp1.pop_front();
                if (bus.r1_dout !== e1) begin
                    n_err++;
                    $display("FAIL dout1: got %h, required %h", bus.r1_dout, e1);
                end
            end
        end
        if (bus.r0_din_strobe) n_istb0++;
        if (bus.r1_din_strobe) n_istb1++;
        if (bus.r0_err) n_errp0++;
        if (bus.r1_err) n_errp1++;
        if ((bus.r0_ack | bus.r0_dout_strobe | bus.r0_din_strobe | bus.r0_err) &&
            (bus.r1_ack | bus.r1_dout_strobe | bus.r1_din_strobe | bus.r1_err)) n_cross++;
    end

    task automatic do_reset;
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_cmd(input string tag, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.sd_rd || bus.sd_wr) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_cmd: got no sd_rd/sd_wr in 400 cycles, required a command", tag);
        end
    endtask

    task automatic set_ack(input logic v);
        @(posedge clk); #1 bus.sd_ack = v;
        repeat (5) @(posedge clk);
    endtask

    task automatic send_bytes(input bit who, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.sd_dout = i[7:0];
            bus.sd_dout_strobe = 1'b1;
            if (i < 512) begin
                if (who) exp1.push_back(i[7:0]);
                else     exp0.push_back(i[7:0]);
            end
            repeat (2) @(posedge clk);
            #1 bus.sd_dout_strobe = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic fetch_bytes(input bit who, input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = i[7:0] ^ 8'hA5;
            @(posedge clk); #1;
            if (who) bus.r1_din = v;
            else     bus.r0_din = v;
            bus.sd_din_strobe = 1'b1;
            @(negedge clk);
            n_vec++;
            if (bus.sd_din !== v) begin
                n_err++;
                $display("FAIL sd_din[%0d]: got %h, required %h", i, bus.sd_din, v);
            end
            repeat (2) @(posedge clk);
            #1 bus.sd_din_strobe = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus.r0_din = 8'h77;
        bus.r0_rd = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr, bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {bus.sd_rd, bus.sd_wr, bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err});
        end
        n_vec++;
        if (bus.sd_lba !== 32'h0) begin
            n_err++;
            $display("FAIL reset_lba: got %h, required 0", bus.sd_lba);
        end
        n_vec++;
        if ({bus.r0_dout, bus.r1_dout, bus.sd_din} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h, required 0", {bus.r0_dout, bus.r1_dout, bus.sd_din});
        end
        bus.r0_rd = 1'b0;
        bus.r0_din = 8'h00;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_read_basic;
        bit ok;
        int d0, er0;
        d0 = n_dstb0; er0 = n_errp0;
        @(posedge clk); #1 bus.r0_lba = 32'h0000_1234; bus.r0_rd = 1'b1;
        wait_cmd("read", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b10 || bus.sd_lba !== 32'h1234) begin
            n_err++;
            $display("FAIL read_cmd: got rd/wr=%b lba=%h, required 10 lba=00001234",
                     {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r0_rd = 1'b0;
        set_ack(1'b1);
        @(negedge clk);
        n_vec++;
        if ({bus.r0_ack, bus.r1_ack, bus.sd_rd} !== 3'b100) begin
            n_err++;
            $display("FAIL read_xfer: got ack0/ack1/sd_rd=%b, required 100", {bus.r0_ack, bus.r1_ack, bus.sd_rd});
        end
        send_bytes(1'b0, 512);
        set_ack(1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_dstb0 - d0 !== 512 || exp0.size() !== 0) begin
            n_err++;
            $display("FAIL read_count: got %0d strobes (%0d pending), required 512 (0)", n_dstb0 - d0, exp0.size());
        end
        n_vec++;
        if (n_errp0 - er0 !== 0 || bus.r0_ack !== 1'b0) begin
            n_err++;
            $display("FAIL read_end: got err=%0d ack=%b, required err=0 ack=0", n_errp0 - er0, bus.r0_ack);
        end
    endtask

    task automatic test_tie;
        bit ok;
        int d0, er0, er1, i1;
        do_reset();
        d0 = n_dstb0; er0 = n_errp0; er1 = n_errp1; i1 = n_istb1;
        @(posedge clk); #1;
        bus.r0_lba = 32'hA0A0_0000; bus.r0_rd = 1'b1;
        bus.r1_lba = 32'hB1B1_0001; bus.r1_wr = 1'b1;
        wait_cmd("tie1", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b10 || bus.sd_lba !== 32'hA0A0_0000) begin
            n_err++;
            $display("FAIL tie1_grant: got rd/wr=%b lba=%h, required 10 lba=a0a00000", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r0_rd = 1'b0;
        set_ack(1'b1);
        send_bytes(1'b0, 514);
        set_ack(1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (n_dstb0 - d0 !== 512 || n_errp0 - er0 !== 0) begin
            n_err++;
            $display("FAIL overflow: got %0d strobes err=%0d, required 512 err=0", n_dstb0 - d0, n_errp0 - er0);
        end
        wait_cmd("tie2", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b01 || bus.sd_lba !== 32'hB1B1_0001) begin
            n_err++;
            $display("FAIL tie2_grant: got rd/wr=%b lba=%h, required 01 lba=b1b10001", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r1_wr = 1'b0;
        bus.r0_rd = 1'b1;
        set_ack(1'b1);
        fetch_bytes(1'b1, 3);
        @(posedge clk); #1 bus.r1_wr = 1'b1;
        set_ack(1'b0);
        wait_cmd("tie3", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b10 || bus.sd_lba !== 32'hA0A0_0000) begin
            n_err++;
            $display("FAIL tie3_grant: got rd/wr=%b lba=%h, required 10 lba=a0a00000", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r0_rd = 1'b0;
        set_ack(1'b1);
        send_bytes(1'b0, 512);
        set_ack(1'b0);
        wait_cmd("tie4", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b01 || bus.sd_lba !== 32'hB1B1_0001) begin
            n_err++;
            $display("FAIL tie4_grant: got rd/wr=%b lba=%h, required 01 lba=b1b10001", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r1_wr = 1'b0;
        set_ack(1'b1);
        set_ack(1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (n_errp0 - er0 !== 0 || n_errp1 - er1 !== 0 || n_istb1 - i1 !== 3) begin
            n_err++;
            $display("FAIL tie_end: got err0=%0d err1=%0d din1=%0d, required 0 0 3",
                     n_errp0 - er0, n_errp1 - er1, n_istb1 - i1);
        end
    endtask

    task automatic test_short_read;
        bit ok;
        int er0;
        er0 = n_errp0;
        @(posedge clk); #1 bus.r0_lba = 32'h0000_0300; bus.r0_rd = 1'b1;
        wait_cmd("short", ok);
        bus.r0_rd = 1'b0;
        set_ack(1'b1);
        send_bytes(1'b0, 300);
        set_ack(1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_errp0 - er0 !== 1 || exp0.size() !== 0) begin
            n_err++;
            $display("FAIL short_err: got %0d err pulses (%0d pending), required 1 (0)", n_errp0 - er0, exp0.size());
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int k, er1;
        er1 = n_errp1;
        @(posedge clk); #1 bus.r1_lba = 32'hCAFE_0001; bus.r1_rd = 1'b1;
        wait_cmd("tmo", ok);
        bus.r1_rd = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        k = 0;
        while (bus.sd_rd && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k !== 100) begin
            n_err++;
            $display("FAIL tmo_cycle: got sd_rd drop after %0d cycles, required 100", k);
        end
        n_vec++;
        if (bus.r1_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_err: got r1_err=%b at drop, required 1", bus.r1_err);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_errp1 - er1 !== 1) begin
            n_err++;
            $display("FAIL tmo_errcnt: got %0d pulses, required 1", n_errp1 - er1);
        end
`else
        k = 0;
        repeat (10000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (bus.sd_rd !== 1'b1 || n_errp1 - er1 !== 0) begin
            n_err++;
            $display("FAIL tmo_wait: got sd_rd=%b err=%0d after %0d cycles, required 1 and 0", bus.sd_rd, n_errp1 - er1, k);
        end
        do_reset();
`endif
    endtask

    task automatic test_write_513;
        bit ok;
        int i1, i0, er1;
        i1 = n_istb1; i0 = n_istb0; er1 = n_errp1;
        @(posedge clk); #1 bus.r1_lba = 32'h0000_0513; bus.r1_wr = 1'b1;
        wait_cmd("write", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b01 || bus.sd_lba !== 32'h513) begin
            n_err++;
            $display("FAIL write_cmd: got rd/wr=%b lba=%h, required 01 lba=00000513", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r1_wr = 1'b0;
        set_ack(1'b1);
        fetch_bytes(1'b1, 513);
        set_ack(1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_istb1 - i1 !== 513 || n_istb0 - i0 !== 0 || n_errp1 - er1 !== 0) begin
            n_err++;
            $display("FAIL write_end: got din1=%0d din0=%0d err=%0d, required 513 0 0",
                     n_istb1 - i1, n_istb0 - i0, n_errp1 - er1);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int er0, er1, i1;
        er0 = n_errp0;
        @(posedge clk); #1 bus.r0_lba = 32'h0000_0055; bus.r0_rd = 1'b1;
        wait_cmd("rstmid", ok);
        bus.r0_rd = 1'b0;
        set_ack(1'b1);
        send_bytes(1'b0, 200);
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.r0_ack, bus.sd_rd, bus.r0_dout_strobe, bus.r0_err} !== 4'b0 ||
            bus.r0_dout !== 8'h0 || bus.sd_lba !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_out: got ctl=%b dout=%h lba=%h, required 0",
                     {bus.r0_ack, bus.sd_rd, bus.r0_dout_strobe, bus.r0_err}, bus.r0_dout, bus.sd_lba);
        end
        bus.sd_ack = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_errp0 - er0 !== 0 || exp0.size() !== 0) begin
            n_err++;
            $display("FAIL rstmid_err: got %0d err (%0d pending), required 0 (0)", n_errp0 - er0, exp0.size());
        end
        er1 = n_errp1; i1 = n_istb1;
        @(posedge clk); #1 bus.r1_lba = 32'h0000_0099; bus.r1_wr = 1'b1;
        wait_cmd("postrst", ok);
        n_vec++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b01 || bus.sd_lba !== 32'h99) begin
            n_err++;
            $display("FAIL postrst_cmd: got rd/wr=%b lba=%h, required 01 lba=00000099", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        bus.r1_wr = 1'b0;
        set_ack(1'b1);
        @(negedge clk);
        n_vec++;
        if (bus.r1_ack !== 1'b1) begin
            n_err++;
            $display("FAIL postrst_ack: got %b, required 1", bus.r1_ack);
        end
        fetch_bytes(1'b1, 4);
        set_ack(1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_istb1 - i1 !== 4 || n_errp1 - er1 !== 0 || bus.r1_ack !== 1'b0) begin
            n_err++;
            $display("FAIL postrst_end: got din=%0d err=%0d ack=%b, required 4 0 0", n_istb1 - i1, n_errp1 - er1, bus.r1_ack);
        end
    endtask

    initial begin
        bus.r0_lba = 32'h0; bus.r0_rd = 1'b0; bus.r0_wr = 1'b0; bus.r0_din = 8'h0;
        bus.r1_lba = 32'h0; bus.r1_rd = 1'b0; bus.r1_wr = 1'b0; bus.r1_din = 8'h0;
        bus.sd_ack = 1'b0; bus.sd_dout = 8'h0; bus.sd_dout_strobe = 1'b0; bus.sd_din_strobe = 1'b0;
        test_reset();
        test_read_basic();
        test_tie();
        test_short_read();
        test_timeout();
        test_write_513();
        test_reset_mid();
        n_vec++;
        if (n_cross !== 0) begin
            n_err++;
            $display("FAIL exclusive: got %0d cycles with both requesters active, required 0", n_cross);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
